decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Decode stage sitting directly downstream of the fetch stage. Consumes instruction_t words (opcode/reg_s1/reg_s2/reg_dst/imm) plus the PC over a valid/ready handshake.
- Buffers them through a 1-entry skid register and a 1-entry output register.
- Detects register RAW/WAW hazards with a pending-write scoreboard and emits decoded control to the execute stage.
- Writeback returns clear scoreboard bits.

Parameters:
- REG_NUM, 4, number of architectural registers; REG_BITS = $clog2(REG_NUM) = 2.
- IMM_BITS, 8, immediate width.
- PC_NUM, 7, instruction memory depth; PC_BITS = $clog2(PC_NUM) = 3.
- OPCODE_W, 3, opcode field width; INS_SIZE = OPCODE_W + 3*REG_BITS + IMM_BITS = 17.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_valid_i  in  1  fetch presents an instruction.
- fetch_ready_o  out  1  decode can accept this cycle.
- fetch_instr_i  in  INS_SIZE  instruction_t: [16:14] opcode, [13:12] rs1, [11:10] rs2, [9:8] rd, [7:0] imm.
- fetch_pc_i  in  PC_BITS  PC of fetch_instr_i.
- dec_valid_o  out  1  decoded instruction valid.
- dec_ready_i  in  1  execute accepts.
- dec_opcode_o  out  OPCODE_W  opcode (0 nop, 1 add, 2 mov).
- dec_rs1_o, dec_rs2_o, dec_rd_o  out  REG_BITS each  register fields.
- dec_imm_o  out  IMM_BITS  immediate.
- dec_pc_o  out  PC_BITS  PC.
- dec_we_o  out  1  writes rd (add, mov).
- dec_use_imm_o  out  1  operand is imm (mov).
- dec_illegal_o  out  1  opcode 3..7 seen; decoded as nop.
- wb_valid_i  in  1  writeback retiring a register write.
- wb_rd_i  in  REG_BITS  register being written back.
- flush_i  in  1  discard all buffered instructions.

Behaviour:
- Handshakes:
  - Fetch transfer = fetch_valid_i & fetch_ready_o.
  - Output transfer = dec_valid_o & dec_ready_i.
  - dec_valid_o and payload are held stable until transferred.
- fetch_ready_o = ~skid_full & ~rst. Driven from registered state only, with no combinational path from dec_ready_i.
- Head instruction = skid entry if skid_full, else the fetch input.
- Decode rules:
  - add: reads rs1, rs2; writes rd; use_imm=0.
  - mov: rd <= imm; reads none; we=1; use_imm=1.
  - nop: we=0.
  - Opcode >= 3: we=0, use_imm=0, illegal=1, passed through as nop.
- Hazard: head stalls if any of the following holds.
  - It reads a register with scoreboard bit set (add: rs1 or rs2).
  - It writes rd with scoreboard[rd] set (WAW).
  - A bit being cleared by wb_valid_i/wb_rd_i in the same cycle counts as clear (bypass).
- Issue: head moves into the output register when head valid, no hazard, and (~dec_valid_o | dec_ready_i).
- Skid fill: if a fetch transfer occurs and the head is the fetch input but it cannot issue, it is captured in skid (skid_full <= 1).
- Skid drain: when skid issues, skid_full <= 0. A new fetch transfer cannot occur while skid_full.
- Latency: 1 cycle from fetch transfer to dec_valid_o when unstalled. Sustained throughput is 1/cycle with no hazards. Program order is preserved.
- Scoreboard (REG_NUM bits):
  - Set bit rd when an instruction with we=1 loads into the output register.
  - Clear bit wb_rd_i when wb_valid_i.
  - Set and clear of the same bit in one cycle: set wins.
- flush_i:
  - Next edge clears skid_full and dec_valid_o.
  - The fetch input that cycle is dropped, with no issue and no scoreboard set.
  - Scoreboard is retained; wb in the same cycle still clears.
  - fetch_ready_o = 1 the following cycle.
- Reset (also mid-operation) clears, at the next edge:
  - skid_full, scoreboard, and all dec_* outputs (0).
  - fetch_ready_o = 0 while rst is high.

Test Plan:
- Reset, then stream nop, mov r1 #0x05, mov r2 #0x0A with dec_ready_i=1 → each appears 1 cycle after fetch transfer; mov has we=1, use_imm=1, imm 0x05/0x0A; scoreboard=0b0110.
- mov r1 #3 then add r3=r1+r2 (scoreboard r1 set) → add stalls, fetch_ready_o drops to 0 after skid fills. wb_valid_i with wb_rd_i=1 → add issues the same cycle's edge (bypass) and fetch_ready_o returns to 1 the following cycle.
- dec_ready_i=0 for 3 cycles with fetch streaming → output holds first instruction stable, skid holds second, fetch_ready_o=0. Release → instructions emerge in order with none lost or duplicated.
- Fetch opcode 5 → dec_illegal_o=1, dec_we_o=0, scoreboard unchanged.
- flush_i with skid and output full plus fetch_valid_i=1 → next cycle dec_valid_o=0, skid empty, fetch_ready_o=1; scoreboard bits from already-issued movs remain.
- WAW: mov r2 pending, then mov r2 #7 → stalls until wb_rd_i=2. Same-cycle wb clear and new set of r2 → bit ends set.

Source files
------------

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_if
// Brief    : Fetch / decode-output / writeback / flush bundle for decode_stage.
//            slave modport is the decode stage, master is its environment.
// Revision : 1.0  initial release
// ============================================================================
interface decode_stage_if #(
   parameter int REG_NUM  = 4,
   parameter int IMM_BITS = 8,
   parameter int PC_NUM   = 7,
   parameter int OPCODE_W = 3
) ();
   localparam int REG_BITS = $clog2(REG_NUM);
   localparam int PC_BITS  = $clog2(PC_NUM);
   localparam int INS_SIZE = OPCODE_W + 3 * REG_BITS + IMM_BITS;

   logic                fetch_valid_i;
   logic                fetch_ready_o;
   logic [INS_SIZE-1:0] fetch_instr_i;
   logic [PC_BITS-1:0]  fetch_pc_i;

   logic                dec_valid_o;
   logic                dec_ready_i;
   logic [OPCODE_W-1:0] dec_opcode_o;
   logic [REG_BITS-1:0] dec_rs1_o;
   logic [REG_BITS-1:0] dec_rs2_o;
   logic [REG_BITS-1:0] dec_rd_o;
   logic [IMM_BITS-1:0] dec_imm_o;
   logic [PC_BITS-1:0]  dec_pc_o;
   logic                dec_we_o;
   logic                dec_use_imm_o;
   logic                dec_illegal_o;

   logic                wb_valid_i;
   logic [REG_BITS-1:0] wb_rd_i;
   logic                flush_i;

   modport slave (
      input  fetch_valid_i, fetch_instr_i, fetch_pc_i, dec_ready_i,
             wb_valid_i, wb_rd_i, flush_i,
      output fetch_ready_o, dec_valid_o, dec_opcode_o, dec_rs1_o, dec_rs2_o,
             dec_rd_o, dec_imm_o, dec_pc_o, dec_we_o, dec_use_imm_o, dec_illegal_o
   );

   modport master (
      output fetch_valid_i, fetch_instr_i, fetch_pc_i, dec_ready_i,
             wb_valid_i, wb_rd_i, flush_i,
      input  fetch_ready_o, dec_valid_o, dec_opcode_o, dec_rs1_o, dec_rs2_o,
             dec_rd_o, dec_imm_o, dec_pc_o, dec_we_o, dec_use_imm_o, dec_illegal_o
   );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : Decode stage with 1-entry skid buffer, 1-entry output register
//            and a pending-write scoreboard for RAW/WAW hazard stalls.
// Revision : 1.0  initial release
// ============================================================================
module decode_stage #(
   parameter int REG_NUM  = 4,
   parameter int IMM_BITS = 8,
   parameter int PC_NUM   = 7,
   parameter int OPCODE_W = 3
) (
   input  wire logic clk,
   input  wire logic rst,
   decode_stage_if.slave bus
);
   localparam int REG_BITS = $clog2(REG_NUM);
   localparam int PC_BITS  = $clog2(PC_NUM);
   localparam int INS_SIZE = OPCODE_W + 3 * REG_BITS + IMM_BITS;

   localparam logic [OPCODE_W-1:0] OP_NOP = OPCODE_W'(0);
   localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(1);
   localparam logic [OPCODE_W-1:0] OP_MOV = OPCODE_W'(2);

   typedef struct packed {
      logic [OPCODE_W-1:0] opcode;
      logic [REG_BITS-1:0] rs1;
      logic [REG_BITS-1:0] rs2;
      logic [REG_BITS-1:0] rd;
      logic [IMM_BITS-1:0] imm;
      logic [PC_BITS-1:0]  pc;
      logic                we;
      logic                use_imm;
      logic                illegal;
   } dec_t;

   // State
   logic                skid_full_q, skid_full_d;
   logic [INS_SIZE-1:0] skid_instr_q, skid_instr_d;
   logic [PC_BITS-1:0]  skid_pc_q, skid_pc_d;
   logic                out_valid_q, out_valid_d;
   dec_t                out_q, out_d;
   logic [REG_NUM-1:0]  scoreboard_q, scoreboard_d;

   // Head / decode / hazard
   logic [INS_SIZE-1:0] head_instr;
   logic [PC_BITS-1:0]  head_pc;
   logic                head_valid;
   logic [OPCODE_W-1:0] head_op;
   dec_t                head_dec;
   logic                head_reads;
   logic [REG_NUM-1:0]  wb_clr;
   logic [REG_NUM-1:0]  sb_eff;
   logic                hazard;
   logic                out_free;
   logic                issue;
   logic                fetch_xfer;

   // Ready depends only on the skid flop and reset, never on dec_ready_i.
   assign bus.fetch_ready_o = ~skid_full_q & ~rst;
   assign fetch_xfer        = bus.fetch_valid_i & bus.fetch_ready_o;

   // Select the oldest instruction and decode its control fields.
   always_comb begin
      head_instr = skid_full_q ? skid_instr_q : bus.fetch_instr_i;
      head_pc    = skid_full_q ? skid_pc_q    : bus.fetch_pc_i;
      head_valid = skid_full_q | fetch_xfer;
      head_op    = head_instr[INS_SIZE-1 -: OPCODE_W];

      head_dec.rs1     = head_instr[IMM_BITS+3*REG_BITS-1 -: REG_BITS];
      head_dec.rs2     = head_instr[IMM_BITS+2*REG_BITS-1 -: REG_BITS];
      head_dec.rd      = head_instr[IMM_BITS+REG_BITS-1 -: REG_BITS];
      head_dec.imm     = head_instr[IMM_BITS-1:0];
      head_dec.pc      = head_pc;
      head_dec.opcode  = OP_NOP;
      head_dec.we      = 1'b0;
      head_dec.use_imm = 1'b0;
      head_dec.illegal = 1'b0;
      head_reads       = 1'b0;
      case (head_op)
         OP_NOP: ;
         OP_ADD: begin
            head_dec.opcode = OP_ADD;
            head_dec.we     = 1'b1;
            head_reads      = 1'b1;
         end
         OP_MOV: begin
            head_dec.opcode  = OP_MOV;
            head_dec.we      = 1'b1;
            head_dec.use_imm = 1'b1;
         end
         default: head_dec.illegal = 1'b1;  // passed through as a nop
      endcase
   end

   // Hazard check against the scoreboard with same-cycle writeback bypass.
   always_comb begin
      wb_clr = '0;
      if (bus.wb_valid_i) wb_clr[bus.wb_rd_i] = 1'b1;
      sb_eff = scoreboard_q & ~wb_clr;
      hazard = (head_reads & (sb_eff[head_dec.rs1] | sb_eff[head_dec.rs2])) |
               (head_dec.we & sb_eff[head_dec.rd]);
      out_free = ~out_valid_q | bus.dec_ready_i;
      issue    = head_valid & ~hazard & out_free & ~bus.flush_i;
   end

   // Next-state for skid, output register and scoreboard.
   always_comb begin
      skid_full_d  = skid_full_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      out_valid_d  = out_valid_q;
      out_d        = out_q;
      scoreboard_d = scoreboard_q & ~wb_clr;

      if (bus.flush_i) begin
         skid_full_d = 1'b0;
         out_valid_d = 1'b0;
      end else begin
         if (skid_full_q && issue) begin
            skid_full_d = 1'b0;
         end else if (!skid_full_q && fetch_xfer && !issue) begin
            skid_full_d  = 1'b1;
            skid_instr_d = bus.fetch_instr_i;
            skid_pc_d    = bus.fetch_pc_i;
         end

         if (issue) begin
            out_valid_d = 1'b1;
            out_d       = head_dec;
            if (head_dec.we) scoreboard_d[head_dec.rd] = 1'b1;  // set beats clear
         end else if (out_valid_q && bus.dec_ready_i) begin
            out_valid_d = 1'b0;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         skid_full_q  <= 1'b0;
         skid_instr_q <= '0;
         skid_pc_q    <= '0;
         out_valid_q  <= 1'b0;
         out_q        <= '0;
         scoreboard_q <= '0;
      end else begin
         skid_full_q  <= skid_full_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
         out_valid_q  <= out_valid_d;
         out_q        <= out_d;
         scoreboard_q <= scoreboard_d;
      end
   end

   assign bus.dec_valid_o   = out_valid_q;
   assign bus.dec_opcode_o  = out_q.opcode;
   assign bus.dec_rs1_o     = out_q.rs1;
   assign bus.dec_rs2_o     = out_q.rs2;
   assign bus.dec_rd_o      = out_q.rd;
   assign bus.dec_imm_o     = out_q.imm;
   assign bus.dec_pc_o      = out_q.pc;
   assign bus.dec_we_o      = out_q.we;
   assign bus.dec_use_imm_o = out_q.use_imm;
   assign bus.dec_illegal_o = out_q.illegal;
endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Brief    : Self-checking bench for decode_stage; expected decode results
//            are queued at fetch transfer and compared at output transfer.
// Revision : 1.0  initial release
// ============================================================================
module tb_decode_stage;
   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [22:0] exp_q [$];

   decode_stage_if bus ();

   decode_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [16:0] ins(input logic [2:0] op, input logic [1:0] s1,
                                       input logic [1:0] s2, input logic [1:0] d,
                                       input logic [7:0] imm);
      return {op, s1, s2, d, imm};
   endfunction

   // Independent reference decode: {opcode,rs1,rs2,rd,imm,pc,we,use_imm,illegal}
   function automatic logic [22:0] model(input logic [16:0] i, input logic [2:0] pc);
      logic [2:0]  op;
      logic [13:0] flds;
      op   = i[16:14];
      flds = i[13:0];
      case (op)
         3'd0:    return {3'd0, flds, pc, 3'b000};
         3'd1:    return {3'd1, flds, pc, 3'b100};
         3'd2:    return {3'd2, flds, pc, 3'b110};
         default: return {3'd0, flds, pc, 3'b001};
      endcase
   endfunction

   // Scoreboard: pop on output transfer, push on fetch transfer.
   always @(negedge clk) begin
      logic [22:0] got;
      logic [22:0] exp;
      if (rst || bus.flush_i) begin
         exp_q.delete();
      end else begin
         if (bus.dec_valid_o && bus.dec_ready_i) begin
            got = {bus.dec_opcode_o, bus.dec_rs1_o, bus.dec_rs2_o, bus.dec_rd_o,
                   bus.dec_imm_o, bus.dec_pc_o, bus.dec_we_o, bus.dec_use_imm_o,
                   bus.dec_illegal_o};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected got %h exp none", got);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp) begin
                  errors++;
                  $display("FAIL sb_payload got %h exp %h", got, exp);
               end
            end
         end
         if (bus.fetch_valid_i && bus.fetch_ready_o)
            exp_q.push_back(model(bus.fetch_instr_i, bus.fetch_pc_i));
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic v, input logic [16:0] i, input logic [2:0] pc);
      bus.fetch_valid_i = v;
      bus.fetch_instr_i = i;
      bus.fetch_pc_i    = pc;
   endtask

   task automatic wb_clear(input logic [1:0] r);
      bus.wb_valid_i = 1'b1;
      bus.wb_rd_i    = r;
      cyc();
      bus.wb_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      fetch(1'b0, '0, '0);
      bus.dec_ready_i = 1'b0;
      bus.wb_valid_i  = 1'b0;
      bus.wb_rd_i     = '0;
      bus.flush_i     = 1'b0;
      cyc(3);
      checks++;
      if (bus.fetch_ready_o !== 1'b0) begin
         errors++; $display("FAIL rst_ready got %b exp 0", bus.fetch_ready_o);
      end
      checks++;
      if ({bus.dec_valid_o, bus.dec_opcode_o, bus.dec_imm_o, bus.dec_we_o,
           bus.dec_illegal_o} !== '0) begin
         errors++; $display("FAIL rst_outputs got %b/%h exp 0", bus.dec_valid_o, bus.dec_imm_o);
      end
      checks++;
      if (dut.scoreboard_q !== 4'b0000) begin
         errors++; $display("FAIL rst_scoreboard got %b exp 0000", dut.scoreboard_q);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (bus.fetch_ready_o !== 1'b1) begin
         errors++; $display("FAIL rst_release_ready got %b exp 1", bus.fetch_ready_o);
      end
   endtask

   task automatic test_stream();
      bus.dec_ready_i = 1'b1;
      fetch(1'b1, ins(3'd0, 2'd0, 2'd0, 2'd0, 8'h00), 3'd0);
      cyc();
      checks++;
      if (bus.dec_valid_o !== 1'b1 || bus.dec_opcode_o !== 3'd0 || bus.dec_we_o !== 1'b0) begin
         errors++; $display("FAIL stream_nop got v%b op%0d we%b exp v1 op0 we0",
                            bus.dec_valid_o, bus.dec_opcode_o, bus.dec_we_o);
      end
      fetch(1'b1, ins(3'd2, 2'd0, 2'd0, 2'd1, 8'h05), 3'd1);
      cyc();
      checks++;
      if (bus.dec_valid_o !== 1'b1 || bus.dec_we_o !== 1'b1 || bus.dec_use_imm_o !== 1'b1 ||
          bus.dec_imm_o !== 8'h05) begin
         errors++; $display("FAIL stream_mov1 got v%b we%b ui%b imm%h exp v1 we1 ui1 imm05",
                            bus.dec_valid_o, bus.dec_we_o, bus.dec_use_imm_o, bus.dec_imm_o);
      end
      fetch(1'b1, ins(3'd2, 2'd0, 2'd0, 2'd2, 8'h0A), 3'd2);
      cyc();
      checks++;
      if (bus.dec_valid_o !== 1'b1 || bus.dec_imm_o !== 8'h0A || bus.dec_rd_o !== 2'd2) begin
         errors++; $display("FAIL stream_mov2 got v%b imm%h rd%0d exp v1 imm0a rd2",
                            bus.dec_valid_o, bus.dec_imm_o, bus.dec_rd_o);
      end
      fetch(1'b0, '0, '0);
      cyc();
      checks++;
      if (dut.scoreboard_q !== 4'b0110) begin
         errors++; $display("FAIL stream_scoreboard got %b exp 0110", dut.scoreboard_q);
      end
      wb_clear(2'd1);
      wb_clear(2'd2);
   endtask

   task automatic test_raw();
      bus.dec_ready_i = 1'b1;
      fetch(1'b1, ins(3'd2, 2'd0, 2'd0, 2'd1, 8'h03), 3'd3);
      cyc();
      fetch(1'b1, ins(3'd1, 2'd1, 2'd2, 2'd3, 8'h00), 3'd4);
      cyc();
      fetch(1'b0, '0, '0);
      checks++;
      if (bus.fetch_ready_o !== 1'b0 || bus.dec_valid_o !== 1'b0) begin
         errors++; $display("FAIL raw_stall got rdy%b v%b exp rdy0 v0",
                            bus.fetch_ready_o, bus.dec_valid_o);
      end
      checks++;
      if (dut.scoreboard_q !== 4'b0010) begin
         errors++; $display("FAIL raw_sb_pending got %b exp 0010", dut.scoreboard_q);
      end
      cyc();
      checks++;
      if (bus.dec_valid_o !== 1'b0) begin
         errors++; $display("FAIL raw_still_stalled got v%b exp v0", bus.dec_valid_o);
      end
      bus.wb_valid_i = 1'b1;
      bus.wb_rd_i    = 2'd1;
      cyc();
      bus.wb_valid_i = 1'b0;
      checks++;
      if (bus.dec_valid_o !== 1'b1 || bus.dec_opcode_o !== 3'd1 || bus.fetch_ready_o !== 1'b1) begin
         errors++; $display("FAIL raw_bypass_issue got v%b op%0d rdy%b exp v1 op1 rdy1",
                            bus.dec_valid_o, bus.dec_opcode_o, bus.fetch_ready_o);
      end
      cyc();
      checks++;
      if (dut.scoreboard_q !== 4'b1000) begin
         errors++; $display("FAIL raw_sb_after got %b exp 1000", dut.scoreboard_q);
      end
      wb_clear(2'd3);
   endtask

   task automatic test_backpressure();
      bus.dec_ready_i = 1'b0;
      fetch(1'b1, ins(3'd0, 2'd1, 2'd2, 2'd3, 8'h11), 3'd5);
      cyc();
      fetch(1'b1, ins(3'd0, 2'd2, 2'd3, 2'd0, 8'h22), 3'd6);
      cyc();
      fetch(1'b1, ins(3'd0, 2'd3, 2'd0, 2'd1, 8'h33), 3'd0);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (bus.dec_valid_o !== 1'b1 || bus.dec_imm_o !== 8'h11 || bus.fetch_ready_o !== 1'b0) begin
            errors++; $display("FAIL bp_hold%0d got v%b imm%h rdy%b exp v1 imm11 rdy0",
                               k, bus.dec_valid_o, bus.dec_imm_o, bus.fetch_ready_o);
         end
         cyc();
      end
      bus.dec_ready_i = 1'b1;
      cyc();
      checks++;
      if (bus.dec_valid_o !== 1'b1 || bus.dec_imm_o !== 8'h22 || bus.fetch_ready_o !== 1'b1) begin
         errors++; $display("FAIL bp_second got v%b imm%h rdy%b exp v1 imm22 rdy1",
                            bus.dec_valid_o, bus.dec_imm_o, bus.fetch_ready_o);
      end
      cyc();
      fetch(1'b0, '0, '0);
      checks++;
      if (bus.dec_valid_o !== 1'b1 || bus.dec_imm_o !== 8'h33) begin
         errors++; $display("FAIL bp_third got v%b imm%h exp v1 imm33",
                            bus.dec_valid_o, bus.dec_imm_o);
      end
      cyc();
   endtask

   task automatic test_illegal();
      bus.dec_ready_i = 1'b1;
      fetch(1'b1, ins(3'd5, 2'd1, 2'd2, 2'd3, 8'h55), 3'd1);
      cyc();
      fetch(1'b0, '0, '0);
      checks++;
      if (bus.dec_valid_o !== 1'b1 || bus.dec_illegal_o !== 1'b1 || bus.dec_we_o !== 1'b0 ||
          bus.dec_use_imm_o !== 1'b0 || bus.dec_opcode_o !== 3'd0) begin
         errors++; $display("FAIL illegal_decode got v%b il%b we%b ui%b op%0d exp v1 il1 we0 ui0 op0",
                            bus.dec_valid_o, bus.dec_illegal_o, bus.dec_we_o,
                            bus.dec_use_imm_o, bus.dec_opcode_o);
      end
      cyc();
      checks++;
      if (dut.scoreboard_q !== 4'b0000) begin
         errors++; $display("FAIL illegal_sb got %b exp 0000", dut.scoreboard_q);
      end
   endtask

   task automatic test_flush();
      bus.dec_ready_i = 1'b0;
      fetch(1'b1, ins(3'd2, 2'd0, 2'd0, 2'd1, 8'h01), 3'd2);
      cyc();
      fetch(1'b1, ins(3'd2, 2'd0, 2'd0, 2'd2, 8'h02), 3'd3);
      cyc();
      fetch(1'b1, ins(3'd2, 2'd0, 2'd0, 2'd3, 8'h03), 3'd4);
      bus.flush_i = 1'b1;
      cyc();
      bus.flush_i = 1'b0;
      fetch(1'b0, '0, '0);
      checks++;
      if (bus.dec_valid_o !== 1'b0 || dut.skid_full_q !== 1'b0 || bus.fetch_ready_o !== 1'b1) begin
         errors++; $display("FAIL flush_clear got v%b skid%b rdy%b exp v0 skid0 rdy1",
                            bus.dec_valid_o, dut.skid_full_q, bus.fetch_ready_o);
      end
      checks++;
      if (dut.scoreboard_q !== 4'b0010) begin
         errors++; $display("FAIL flush_sb_kept got %b exp 0010", dut.scoreboard_q);
      end
      // flush while the fetch input actually transfers: it must be dropped
      fetch(1'b1, ins(3'd2, 2'd0, 2'd0, 2'd3, 8'h04), 3'd5);
      bus.flush_i = 1'b1;
      cyc();
      bus.flush_i = 1'b0;
      fetch(1'b0, '0, '0);
      checks++;
      if (bus.dec_valid_o !== 1'b0 || dut.scoreboard_q !== 4'b0010) begin
         errors++; $display("FAIL flush_drop got v%b sb%b exp v0 sb0010",
                            bus.dec_valid_o, dut.scoreboard_q);
      end
      wb_clear(2'd1);
   endtask

   task automatic test_waw();
      bus.dec_ready_i = 1'b1;
      fetch(1'b1, ins(3'd2, 2'd0, 2'd0, 2'd2, 8'h01), 3'd6);
      cyc();
      fetch(1'b1, ins(3'd2, 2'd0, 2'd0, 2'd2, 8'h07), 3'd0);
      cyc();
      fetch(1'b0, '0, '0);
      cyc();
      checks++;
      if (bus.dec_valid_o !== 1'b0 || bus.fetch_ready_o !== 1'b0) begin
         errors++; $display("FAIL waw_stall got v%b rdy%b exp v0 rdy0",
                            bus.dec_valid_o, bus.fetch_ready_o);
      end
      bus.wb_valid_i = 1'b1;
      bus.wb_rd_i    = 2'd2;
      cyc();
      bus.wb_valid_i = 1'b0;
      checks++;
      if (bus.dec_valid_o !== 1'b1 || bus.dec_imm_o !== 8'h07) begin
         errors++; $display("FAIL waw_issue got v%b imm%h exp v1 imm07",
                            bus.dec_valid_o, bus.dec_imm_o);
      end
      cyc();
      checks++;
      if (dut.scoreboard_q !== 4'b0100) begin
         errors++; $display("FAIL waw_set_wins got %b exp 0100", dut.scoreboard_q);
      end
      wb_clear(2'd2);
   endtask

   task automatic test_back_to_back();
      bus.dec_ready_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
         fetch(1'b1, ins(3'd0, 2'(k), 2'(k + 1), 2'(k + 2), 8'(8'h40 + k)), 3'(k));
         cyc();
         checks++;
         if (bus.dec_valid_o !== 1'b1 || bus.fetch_ready_o !== 1'b1 || bus.dec_imm_o !== 8'(8'h40 + k)) begin
            errors++; $display("FAIL b2b_%0d got v%b rdy%b imm%h exp v1 rdy1 imm%h",
                               k, bus.dec_valid_o, bus.fetch_ready_o, bus.dec_imm_o, 8'(8'h40 + k));
         end
      end
      // random valid/ready with non-writing opcodes; checked by the scoreboard queue
      for (int k = 0; k < 60; k++) begin
         logic [2:0] op;
         op = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(3, 7));
         fetch(1'($urandom_range(0, 1)), ins(op, 2'($urandom), 2'($urandom), 2'($urandom),
               8'($urandom)), 3'($urandom_range(0, 6)));
         bus.dec_ready_i = 1'($urandom_range(0, 1));
         cyc();
      end
      fetch(1'b0, '0, '0);
      bus.dec_ready_i = 1'b1;
      cyc(4);
      checks++;
      if (exp_q.size() != 0 || bus.dec_valid_o !== 1'b0) begin
         errors++; $display("FAIL drain got %0d queued v%b exp 0 queued v0",
                            exp_q.size(), bus.dec_valid_o);
      end
   endtask

   task automatic test_mid_reset();
      bus.dec_ready_i = 1'b0;
      fetch(1'b1, ins(3'd2, 2'd0, 2'd0, 2'd3, 8'h09), 3'd1);
      cyc(2);
      rst = 1'b1;
      fetch(1'b0, '0, '0);
      cyc();
      checks++;
      if (bus.dec_valid_o !== 1'b0 || dut.skid_full_q !== 1'b0 || dut.scoreboard_q !== 4'b0000 ||
          bus.fetch_ready_o !== 1'b0 || bus.dec_imm_o !== 8'h00) begin
         errors++; $display("FAIL midrst got v%b skid%b sb%b rdy%b imm%h exp 0 0 0000 0 00",
                            bus.dec_valid_o, dut.skid_full_q, dut.scoreboard_q,
                            bus.fetch_ready_o, bus.dec_imm_o);
      end
      rst = 1'b0;
      cyc();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_stream();
      test_raw();
      test_backpressure();
      test_illegal();
      test_flush();
      test_waw();
      test_back_to_back();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
